return_addr_stack: RTL and testbench

- Parametrised hardware return-address stack for the fetch stage; next generation of the fixed 8x32 PC stack.
- Control unit pushes the return PC on call and pops on return.
- Adds generic width/depth, same-cycle push+pop (replace top), flush, separate sticky overflow/underflow flags, occupancy outputs, and a registered pop result with a valid strobe.

---
 rtl/ras_pkg.sv | 19 +
 rtl/ras_storage.sv | 28 ++
 rtl/return_addr_stack.sv | 174 +++++++++++++++++
 tb/tb_return_addr_stack.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// Shared constants, occupancy-width helper and op codes for the return-address stack.
package ras_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 8;

  // Occupancy runs 0..depth inclusive, so one extra code point is needed.
  function automatic int lvlWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

endpackage

// File: rtl/ras_storage.sv
// Return-address storage: DEPTH x DATA_W registers, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module ras_storage
  import ras_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/return_addr_stack.sv
// Parametrised return-address stack with push/pop/replace, flush, sticky error flags
// and a registered pop result. Define RAS_WRAP_EN for circular overwrite-on-full mode.
module return_addr_stack
  import ras_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int LVL_W  = lvlWidth(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic              clear_err,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [DATA_W-1:0] top_data,
  output logic [LVL_W-1:0]  level,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUM_W = LVL_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  // a < DEPTH and b <= DEPTH, so a single conditional subtract is a full modulo.
  function automatic logic [PTR_W-1:0] modAdd(input logic [PTR_W-1:0] a,
                                               input logic [LVL_W-1:0] b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum >= DEPTH_S) begin
      sum = sum - DEPTH_S;
    end
    return PTR_W'(sum);
  endfunction

  op_e               op;
  logic [LVL_W-1:0]  lvlQ;
  logic [PTR_W-1:0]  basePtr;
  logic [PTR_W-1:0]  topIdx;
  logic [PTR_W-1:0]  pushIdx;
  logic [LVL_W-1:0]  topOff;
  logic              isEmpty;
  logic              isFull;
  logic              wrEn;
  logic [PTR_W-1:0]  wrAddr;
  logic [DATA_W-1:0] rdData;
  logic [DATA_W-1:0] popDataQ;
  logic              popValidQ;
  logic              ovfQ;
  logic              udfQ;
  logic              pushErr;
  logic              popErr;
  logic              ovfNext;
  logic              udfNext;
  logic              pushAccept;

  assign op      = op_e'({push, pop});
  assign isEmpty = (lvlQ == '0);
  assign isFull  = (lvlQ == DEPTH_L);

`ifdef RAS_WRAP_EN
  logic [PTR_W-1:0] basePtrQ;
  assign basePtr    = basePtrQ;
  assign pushAccept = 1'b1;
`else
  assign basePtr    = '0;
  assign pushAccept = !isFull;
`endif

  assign topOff  = isEmpty ? '0 : lvlQ - LVL_W'(1);
  assign topIdx  = modAdd(basePtr, topOff);
  assign pushIdx = modAdd(basePtr, lvlQ);

  // A replace overwrites the current top; a push (or replace on empty) fills the next slot.
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = pushIdx;
    if (reset && !flush) begin
      unique case (op)
        OP_PUSH: wrEn = pushAccept;
        OP_REPL: begin
          wrEn   = 1'b1;
          wrAddr = isEmpty ? pushIdx : topIdx;
        end
        default: wrEn = 1'b0;
      endcase
    end
  end

  ras_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) uStorage (
    .clock  (clock),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (push_data),
    .rdAddr (topIdx),
    .rdData (rdData)
  );

  // A fresh error in the same cycle as clear_err keeps its flag set.
  assign pushErr = !flush && (op == OP_PUSH) && isFull;
  assign popErr  = !flush && pop && isEmpty;
  assign ovfNext = (ovfQ && !clear_err) || pushErr;
  assign udfNext = (udfQ && !clear_err) || popErr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      lvlQ      <= '0;
      popDataQ  <= '0;
      popValidQ <= 1'b0;
      ovfQ      <= 1'b0;
      udfQ      <= 1'b0;
`ifdef RAS_WRAP_EN
      basePtrQ  <= '0;
`endif
    end else begin
      popValidQ <= 1'b0;
      ovfQ      <= ovfNext;
      udfQ      <= udfNext;
      if (flush) begin
        lvlQ <= '0;
      end else begin
        unique case (op)
          OP_POP: begin
            if (!isEmpty) begin
              popDataQ  <= rdData;
              popValidQ <= 1'b1;
              lvlQ      <= lvlQ - LVL_W'(1);
            end
          end
          OP_PUSH: begin
            if (!isFull) begin
              lvlQ <= lvlQ + LVL_W'(1);
            end
`ifdef RAS_WRAP_EN
            else begin
              basePtrQ <= modAdd(basePtrQ, LVL_W'(1));
            end
`endif
          end
          OP_REPL: begin
            if (isEmpty) begin
              lvlQ <= LVL_W'(1);
            end else begin
              popDataQ  <= rdData;
              popValidQ <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign pop_data  = popDataQ;
  assign pop_valid = popValidQ;
  assign top_data  = isEmpty ? '0 : rdData;
  assign level     = lvlQ;
  assign empty     = isEmpty;
  assign full      = isFull;
  assign overflow  = ovfQ;
  assign underflow = udfQ;

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack (DATA_W=32, DEPTH=4), directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_return_addr_stack;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0, pop = 1'b0, flush = 1'b0, clear_err = 1'b0;
  logic [31:0] push_data = '0;
  logic [31:0] pop_data;
  logic        pop_valid;
  logic [31:0] top_data;
  logic [2:0]  level;
  logic        empty, full, overflow, underflow;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: a queue whose back is the top of stack.
  logic [31:0] mq[$];
  logic [31:0] mPopData = '0;
  bit          mPopValid = 0, mOvf = 0, mUdf = 0;

  return_addr_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .clear_err(clear_err), .push_data(push_data), .pop_data(pop_data),
    .pop_valid(pop_valid), .top_data(top_data), .level(level), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  function automatic void modelStep(bit rstn, bit ps, bit pp, bit fl, bit ce, logic [31:0] d);
    if (!rstn) begin
      mq.delete(); mPopData = '0; mPopValid = 0; mOvf = 0; mUdf = 0;
      return;
    end
    mPopValid = 0;
    if (ce) begin mOvf = 0; mUdf = 0; end
    if (fl) begin mq.delete(); return; end
    if (pp) begin
      if (mq.size() == 0) mUdf = 1;
      else begin mPopData = mq.pop_back(); mPopValid = 1; end
      if (ps) mq.push_back(d);
    end else if (ps) begin
      if (mq.size() == DEPTH) begin
        mOvf = 1;
`ifdef RAS_WRAP_EN
        void'(mq.pop_front());
        mq.push_back(d);
`endif
      end else begin
        mq.push_back(d);
      end
    end
  endfunction

  task automatic doCycle(input bit rstn, input bit ps, input bit pp, input bit fl,
                         input bit ce, input logic [31:0] d);
    reset = rstn; push = ps; pop = pp; flush = fl; clear_err = ce; push_data = d;
    @(posedge clock);
    modelStep(rstn, ps, pp, fl, ce, d);
    #1;
  endtask

  task automatic test_reset();
    doCycle(0, 0, 0, 0, 0, '0);
    doCycle(0, 0, 0, 0, 0, '0);
    nChecks++; if (level !== 3'd0) begin nFails++; $display("FAIL reset_level got %0d required 0", level); end
    nChecks++; if (empty !== 1'b1) begin nFails++; $display("FAIL reset_empty got %b required 1", empty); end
    nChecks++; if (full !== 1'b0) begin nFails++; $display("FAIL reset_full got %b required 0", full); end
    nChecks++; if (pop_data !== 32'h0) begin nFails++; $display("FAIL reset_pop_data got %h required 0", pop_data); end
    nChecks++; if (pop_valid !== 1'b0) begin nFails++; $display("FAIL reset_pop_valid got %b required 0", pop_valid); end
    nChecks++; if ({overflow, underflow} !== 2'b00) begin nFails++; $display("FAIL reset_flags got %b required 00", {overflow, underflow}); end
    nChecks++; if (top_data !== 32'h0) begin nFails++; $display("FAIL reset_top got %h required 0", top_data); end
  endtask

  task automatic test_lifo();
    logic [31:0] vals[3];
    vals = '{32'h100, 32'h200, 32'h300};
    doCycle(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) doCycle(1, 1, 0, 0, 0, vals[i]);
    nChecks++; if (level !== 3'd3) begin nFails++; $display("FAIL lifo_level got %0d required 3", level); end
    nChecks++; if (top_data !== 32'h300) begin nFails++; $display("FAIL lifo_top got %h required 300", top_data); end
    for (int i = 2; i >= 0; i--) begin
      doCycle(1, 0, 1, 0, 0, '0);
      nChecks++; if (pop_data !== vals[i] || pop_valid !== 1'b1) begin nFails++; $display("FAIL lifo_pop got %h/%b required %h/1", pop_data, pop_valid, vals[i]); end
      nChecks++; if (level !== 3'(i)) begin nFails++; $display("FAIL lifo_pop_level got %0d required %0d", level, i); end
    end
    doCycle(1, 0, 0, 0, 0, '0);
    nChecks++; if (pop_valid !== 1'b0) begin nFails++; $display("FAIL lifo_strobe got %b required 0", pop_valid); end
    nChecks++; if (empty !== 1'b1) begin nFails++; $display("FAIL lifo_empty got %b required 1", empty); end
  endtask

  task automatic test_underflow();
    doCycle(1, 0, 1, 0, 0, '0);
    nChecks++; if (underflow !== 1'b1) begin nFails++; $display("FAIL udf_flag got %b required 1", underflow); end
    nChecks++; if (pop_valid !== 1'b0) begin nFails++; $display("FAIL udf_valid got %b required 0", pop_valid); end
    nChecks++; if (pop_data !== 32'h100) begin nFails++; $display("FAIL udf_hold got %h required 100", pop_data); end
    doCycle(1, 0, 0, 0, 0, '0);
    nChecks++; if (underflow !== 1'b1) begin nFails++; $display("FAIL udf_sticky got %b required 1", underflow); end
    doCycle(1, 0, 0, 0, 1, '0);
    nChecks++; if (underflow !== 1'b0) begin nFails++; $display("FAIL udf_clear got %b required 0", underflow); end
    doCycle(1, 0, 1, 0, 1, '0);
    nChecks++; if (underflow !== 1'b1) begin nFails++; $display("FAIL udf_clear_vs_err got %b required 1", underflow); end
    doCycle(1, 0, 0, 0, 1, '0);
  endtask

  task automatic test_overflow();
    logic [31:0] expPops[4];
`ifdef RAS_WRAP_EN
    expPops = '{32'hA4, 32'hA3, 32'hA2, 32'hA1};
`else
    expPops = '{32'hA3, 32'hA2, 32'hA1, 32'hA0};
`endif
    for (int i = 0; i < 4; i++) doCycle(1, 1, 0, 0, 0, 32'hA0 + 32'(i));
    nChecks++; if (full !== 1'b1 || level !== 3'd4) begin nFails++; $display("FAIL ovf_full got %b/%0d required 1/4", full, level); end
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL ovf_early got %b required 0", overflow); end
    doCycle(1, 1, 0, 0, 0, 32'hA4);
    nChecks++; if (overflow !== 1'b1) begin nFails++; $display("FAIL ovf_flag got %b required 1", overflow); end
    nChecks++; if (level !== 3'd4) begin nFails++; $display("FAIL ovf_level got %0d required 4", level); end
    for (int i = 0; i < 4; i++) begin
      doCycle(1, 0, 1, 0, 0, '0);
      nChecks++; if (pop_data !== expPops[i] || pop_valid !== 1'b1) begin nFails++; $display("FAIL ovf_pop%0d got %h/%b required %h/1", i, pop_data, pop_valid, expPops[i]); end
    end
    nChecks++; if (empty !== 1'b1) begin nFails++; $display("FAIL ovf_drain got %b required 1", empty); end
    doCycle(1, 0, 0, 0, 1, '0);
    nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL ovf_clear got %b required 0", overflow); end
  endtask

  task automatic test_replace();
    doCycle(1, 1, 0, 0, 0, 32'h10);
    doCycle(1, 1, 0, 0, 0, 32'h20);
    doCycle(1, 1, 1, 0, 0, 32'h30);
    nChecks++; if (pop_data !== 32'h20 || pop_valid !== 1'b1) begin nFails++; $display("FAIL repl_pop got %h/%b required 20/1", pop_data, pop_valid); end
    nChecks++; if (level !== 3'd2) begin nFails++; $display("FAIL repl_level got %0d required 2", level); end
    nChecks++; if (top_data !== 32'h30) begin nFails++; $display("FAIL repl_top got %h required 30", top_data); end
    doCycle(1, 0, 1, 0, 0, '0);
    nChecks++; if (pop_data !== 32'h30) begin nFails++; $display("FAIL repl_next got %h required 30", pop_data); end
    doCycle(1, 0, 1, 0, 0, '0);
    nChecks++; if (pop_data !== 32'h10 || empty !== 1'b1) begin nFails++; $display("FAIL repl_last got %h/%b required 10/1", pop_data, empty); end
    // Replace while full must not raise overflow.
    for (int i = 0; i < 4; i++) doCycle(1, 1, 0, 0, 0, 32'h50 + 32'(i));
    doCycle(1, 1, 1, 0, 0, 32'h5F);
    nChecks++; if (overflow !== 1'b0 || top_data !== 32'h5F || pop_data !== 32'h53) begin nFails++; $display("FAIL repl_full got %b/%h/%h required 0/5f/53", overflow, top_data, pop_data); end
  endtask

  task automatic test_flush_reset();
    doCycle(1, 0, 0, 1, 0, '0);
    for (int i = 1; i <= 3; i++) doCycle(1, 1, 0, 0, 0, 32'(i));
    doCycle(1, 1, 0, 1, 0, 32'h99);
    nChecks++; if (level !== 3'd0 || empty !== 1'b1) begin nFails++; $display("FAIL flush_level got %0d/%b required 0/1", level, empty); end
    nChecks++; if (top_data !== 32'h0) begin nFails++; $display("FAIL flush_top got %h required 0", top_data); end
    doCycle(1, 1, 0, 0, 0, 32'h5);
    doCycle(1, 0, 1, 0, 0, '0);
    doCycle(1, 0, 1, 0, 0, '0);
    nChecks++; if (underflow !== 1'b1 || pop_data !== 32'h5) begin nFails++; $display("FAIL flush_setup got %b/%h required 1/5", underflow, pop_data); end
    doCycle(1, 1, 0, 0, 0, 32'h77);
    doCycle(1, 1, 0, 0, 0, 32'h78);
    doCycle(0, 0, 1, 0, 0, '0);
    nChecks++; if (level !== 3'd0 || pop_valid !== 1'b0 || pop_data !== 32'h0) begin nFails++; $display("FAIL midreset got %0d/%b/%h required 0/0/0", level, pop_valid, pop_data); end
    nChecks++; if ({overflow, underflow} !== 2'b00 || empty !== 1'b1) begin nFails++; $display("FAIL midreset_flags got %b/%b required 00/1", {overflow, underflow}, empty); end
  endtask

  task automatic test_repl_empty();
    doCycle(1, 1, 1, 0, 0, 32'h44);
    nChecks++; if (underflow !== 1'b1 || pop_valid !== 1'b0) begin nFails++; $display("FAIL replempty_flags got %b/%b required 1/0", underflow, pop_valid); end
    nChecks++; if (level !== 3'd1 || top_data !== 32'h44) begin nFails++; $display("FAIL replempty_state got %0d/%h required 1/44", level, top_data); end
    doCycle(1, 0, 0, 0, 1, '0);
  endtask

  task automatic test_random();
    logic [31:0] expTop;
    for (int n = 0; n < 600; n++) begin
      doCycle(($urandom % 100) >= 2, ($urandom % 100) < 50, ($urandom % 100) < 40,
              ($urandom % 100) < 4, ($urandom % 100) < 8, $urandom);
      expTop = (mq.size() > 0) ? mq[mq.size() - 1] : 32'h0;
      nChecks++; if (level !== 3'(mq.size())) begin nFails++; $display("FAIL rnd_level cyc %0d got %0d required %0d", n, level, mq.size()); end
      nChecks++; if (pop_valid !== mPopValid) begin nFails++; $display("FAIL rnd_valid cyc %0d got %b required %b", n, pop_valid, mPopValid); end
      nChecks++; if (pop_data !== mPopData) begin nFails++; $display("FAIL rnd_pop cyc %0d got %h required %h", n, pop_data, mPopData); end
      nChecks++; if (top_data !== expTop) begin nFails++; $display("FAIL rnd_top cyc %0d got %h required %h", n, top_data, expTop); end
      nChecks++; if ({overflow, underflow} !== {mOvf, mUdf}) begin nFails++; $display("FAIL rnd_flags cyc %0d got %b required %b", n, {overflow, underflow}, {mOvf, mUdf}); end
      nChecks++; if ({empty, full} !== {mq.size() == 0, mq.size() == DEPTH}) begin nFails++; $display("FAIL rnd_ef cyc %0d got %b required %b", n, {empty, full}, {mq.size() == 0, mq.size() == DEPTH}); end
    end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_underflow();
    test_overflow();
    test_replace();
    test_flush_reset();
    test_repl_empty();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
